// File: rtl/seven_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_mux
//
// Time-multiplexed N-digit seven-segment display driver. A shadow register
// holds one hex nibble, one decimal-point request and one enable per digit.
// The digits are scanned round-robin, each one selected for REFRESH_DIV clock
// cycles, and the segment lines, decimal point and one-hot digit select are
// all driven from registers.
//
// Parameters:
//   NUM_DIGITS  - number of digits scanned (1..8)
//   REFRESH_DIV - clock cycles each digit stays selected (>= 2)
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   load      in   capture value_in/dp_in/en_in into the shadow registers
//   value_in  in   hex nibbles, digit k = value_in[4k+3:4k], digit 0 rightmost
//   dp_in     in   decimal point request per digit
//   en_in     in   digit enable (0 = blank that digit)
//   seg       out  segments, seg[6]=a ... seg[0]=g, active-high
//   dp        out  decimal point, active-high
//   digit_sel out  one-hot digit select, active-high
//   scan_tick out  one-cycle pulse marking a scan index advance
//
// Optional feature (compile-time macro SEVEN_SEG_LEADING_ZERO_BLANK_EN):
//   when defined, an enabled digit k>0 whose nibble and every higher nibble
//   are zero, and whose decimal point is off, is shown blank. Digit 0 is
//   never suppressed. When undefined, zeros always display as "0".
// -----------------------------------------------------------------------------
module seven_seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    scan_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Hex nibble to abcdefg pattern, bit 6 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow registers: the display only ever reads these, never the raw inputs.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;

  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    en_d    = en_q;
    if (load) begin
      value_d = value_in;
      dp_d    = dp_in;
      en_d    = en_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
    end else begin
      value_q <= value_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh counter and scan index.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cnt_wrap;

  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression flags (per digit, from shadow state only).
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_blank;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // zero_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero; the extra
  // top bit seeds the chain so the most significant digit needs no special case.
  logic [NUM_DIGITS:0] zero_from;

  assign zero_from[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = (value_q[4*gi +: 4] == 4'h0) & zero_from[gi+1];
      if (gi == 0) begin : g_lsd
        // The rightmost digit always shows something, even a lone zero.
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = zero_from[gi] & ~dp_q[gi];
      end
    end
  endgenerate
`else
  assign lz_blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit decoded patterns, then a one-hot AND-OR mux keyed by the select
  // vector for the scan index. Using the same one-hot vector for both the mux
  // and the digit_sel pins keeps them consistent by construction.
  // ---------------------------------------------------------------------------
  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_dp;
  logic [NUM_DIGITS-1:0] sel_d;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic shown;
      assign shown         = en_q[gi] & ~lz_blank[gi];
      assign digit_seg[gi] = shown ? hex_to_seg(value_q[4*gi +: 4]) : 7'd0;
      // A disabled digit hides its decimal point too; suppression only ever
      // applies when dp is already off, so it needs no term here.
      assign digit_dp[gi]  = en_q[gi] & dp_q[gi];
      assign sel_d[gi]     = (idx_q == IDX_W'(gi));
    end
  endgenerate

  logic [6:0] seg_d;
  logic       dp_out_d;
  logic       tick_d;

  always_comb begin
    seg_d    = '0;
    dp_out_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_d[i]) begin
        seg_d    = seg_d | digit_seg[i];
        dp_out_d = dp_out_d | digit_dp[i];
      end
    end
    tick_d = cnt_wrap;
  end

  // ---------------------------------------------------------------------------
  // Output registers: one cycle of latency from the scan index to the pins.
  // ---------------------------------------------------------------------------
  logic [6:0]            seg_q;
  logic                  dp_out_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= '0;
      dp_out_q <= 1'b0;
      sel_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_out_q;
  assign digit_sel = sel_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_mux
//
// Randomised scoreboard bench for seven_seg_scan_mux (NUM_DIGITS=4,
// REFRESH_DIV=4). A reference model derives the expected pins after every
// clock edge from elapsed-cycle arithmetic and pushes them into a queue; a
// monitor on the falling edge pops and compares against the DUT.
// Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_mux;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic            clk;
  logic            rst;
  logic            load;
  logic [4*ND-1:0] value_in;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   en_in;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   digit_sel;
  logic            scan_tick;

  seven_seg_scan_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value_in (value_in),
    .dp_in    (dp_in),
    .en_in    (en_in),
    .seg      (seg),
    .dp       (dp),
    .digit_sel(digit_sel),
    .scan_tick(scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] sel;
    logic          tick;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16];

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
    seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
    seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
    seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
    seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101;
    seg_tab[14] = 7'b1001111; seg_tab[15] = 7'b1000111;
  end

  // ---------------------------------------------------------------------------
  // Reference model: cyc counts edges since reset release. Before edge n the
  // digit being scanned is floor((n-1)/DIV) mod ND, and the tick shows after
  // every DIV-th edge. Shadow updates after the expectation is formed, so a
  // load on an edge is only visible from the following edge.
  // ---------------------------------------------------------------------------
  int            cyc;
  logic [15:0]   sh_val;
  logic [ND-1:0] sh_dp;
  logic [ND-1:0] sh_en;

  task automatic model_step();
    exp_t       e;
    int         cur;
    logic [3:0] nib;
    bit         blank;
    e = '0;
    if (rst) begin
      cyc    = 0;
      sh_val = '0;
      sh_dp  = '0;
      sh_en  = '0;
    end else begin
      cyc++;
      cur        = ((cyc - 1) / DIV) % ND;
      e.sel[cur] = 1'b1;
      e.tick     = ((cyc % DIV) == 0);
      nib        = 4'((sh_val >> (4 * cur)) & 16'hF);
      blank      = !sh_en[cur];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (cur > 0 && (sh_val >> (4 * cur)) == 16'h0 && !sh_dp[cur]) blank = 1'b1;
`endif
      if (!blank) begin
        e.seg = seg_tab[nib];
        e.dp  = sh_dp[cur];
      end
      if (load) begin
        sh_val = value_in;
        sh_dp  = dp_in;
        sh_en  = en_in;
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: the DUT presents a new registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({seg, dp, digit_sel, scan_tick} !== {e.seg, e.dp, e.sel, e.tick}) begin
          errors++;
          $display("FAIL scan_out t=%0t: got seg=%b dp=%b sel=%b tick=%b, expected seg=%b dp=%b sel=%b tick=%b",
                   $time, seg, dp, digit_sel, scan_tick, e.seg, e.dp, e.sel, e.tick);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All are entered just after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic load_word(input logic [15:0] v, input logic [ND-1:0] d,
                           input logic [ND-1:0] en);
    load     = 1'b1;
    value_in = v;
    dp_in    = d;
    en_in    = en;
    $display("load value=%h dp=%b en=%b t=%0t", v, d, en, $time);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (scan_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    rst      = 1'b1;
    load     = 1'b0;
    value_in = '0;
    dp_in    = '0;
    en_in    = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Scan order, loaded on the very first post-reset edge.
    load_word(16'h3A7F, 4'b0100, 4'hF);
    idle(40);

    // Blanking of digits 0 and 2.
    load_word(16'h3A7F, 4'b0100, 4'b1010);
    idle(20);

    // Load colliding with the scan tick.
    for (int k = 0; k < 3; k++) begin
      wait_tick(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tick_timeout: got no scan_tick within %0d cycles, required one", 4 * DIV);
      end
      load_word(16'($urandom), 4'($urandom), 4'hF);
      idle(20);
    end

    // Full decode walk on digit 0.
    for (int n = 0; n < 16; n++) begin
      load_word({12'h9C1, 4'(n)}, 4'b0000, 4'hF);
      idle(ND * DIV);
    end

    // Reset mid-scan: pins clear without waiting for a clock edge.
    idle(5);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg, dp, digit_sel, scan_tick} !== '0) begin
      errors++;
      $display("FAIL async_reset: got seg=%b dp=%b sel=%b tick=%b, required all zero",
               seg, dp, digit_sel, scan_tick);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(8);

    // Leading zeros.
    load_word(16'h0050, 4'b0000, 4'hF);
    idle(20);

    // Randomised loads at random spacing.
    for (int k = 0; k < 40; k++) begin
      load_word(16'($urandom), 4'($urandom), 4'($urandom));
      idle(int'($urandom_range(1, 12)));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
